// File: rtl/mips_16_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips_16_mem_arbiter
//
// Shares one unified single-port 16-bit memory between the instruction-fetch
// port (if_*) and the load/store port (ls_*). Each accepted request is run
// through a fixed MEM_LAT-cycle memory access, followed by a one-cycle DONE
// turnaround, with a registered grant pulse at the start and a registered
// valid pulse at the end.
//
// Parameters:
//   MEM_LAT  memory access cycles per transaction (1..15)
//   AW       address width
//   DW       data width
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   if_req/if_addr             fetch request (read only)
//   if_gnt/if_valid/if_rdata   fetch accept pulse, completion pulse, held data
//   ls_req/ls_we/ls_addr/ls_wdata   load/store request
//   ls_gnt/ls_valid/ls_rdata   load/store accept, completion, held load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory macro interface
//   busy                       high whenever the sequencer is not IDLE
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin between ports on simultaneous
//                               requests (pointer records the last owner)
//                  undefined -> fixed priority, load/store over fetch
// -----------------------------------------------------------------------------
module mips_16_mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_valid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
        $error("mips_16_mem_arbiter: MEM_LAT=%0d is outside 1..15", MEM_LAT);
    end

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          owner_ls_q, owner_ls_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          if_gnt_q, if_gnt_d;
    logic          ls_gnt_q, ls_gnt_d;
    logic          if_valid_q, if_valid_d;
    logic          ls_valid_q, ls_valid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] ls_rdata_q, ls_rdata_d;
    logic          pick_ls;

`ifdef MEM_ARB_RR_EN
    // rr_ls_q = 1 when the most recent grant went to the load/store port.
    // Reset value 0 (fetch) makes the first tie go to load/store.
    logic rr_ls_q, rr_ls_d;

    assign pick_ls = ls_req && (!if_req || !rr_ls_q);

    always_comb begin
        rr_ls_d = rr_ls_q;
        if (state_q == IDLE && (if_req || ls_req)) begin
            rr_ls_d = pick_ls;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ls_q <= 1'b0;
        end else begin
            rr_ls_q <= rr_ls_d;
        end
    end
`else
    assign pick_ls = ls_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_ls_d = owner_ls_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_gnt_d   = 1'b0;
        ls_gnt_d   = 1'b0;
        if_valid_d = 1'b0;
        ls_valid_d = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    owner_ls_d = pick_ls;
                    addr_d     = pick_ls ? ls_addr : if_addr;
                    we_d       = pick_ls && ls_we;
                    wdata_d    = ls_wdata;
                    cnt_d      = CNT_INIT;
                    if_gnt_d   = !pick_ls;
                    ls_gnt_d   = pick_ls;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Read data is only valid in the last enabled cycle;
                    // stores leave both read-data registers untouched.
                    if (!owner_ls_q) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        ls_rdata_d = mem_rdata;
                    end
                    if_valid_d = !owner_ls_q;
                    ls_valid_d = owner_ls_q;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            if_gnt_q   <= 1'b0;
            ls_gnt_q   <= 1'b0;
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if_gnt_q   <= if_gnt_d;
            ls_gnt_q   <= ls_gnt_d;
            if_valid_q <= if_valid_d;
            ls_valid_q <= ls_valid_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Latched transaction; only observed while in ACCESS, so no reset needed.
    always_ff @(posedge clk) begin
        owner_ls_q <= owner_ls_d;
        addr_q     <= addr_d;
        we_q       <= we_d;
        wdata_q    <= wdata_d;
    end

    // Memory outputs are decoded from the state flop so an asynchronous reset
    // removes them in the same cycle.
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign busy      = (state_q != IDLE);

    assign if_gnt   = if_gnt_q;
    assign ls_gnt   = ls_gnt_q;
    assign if_valid = if_valid_q;
    assign ls_valid = ls_valid_q;
    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mips_16_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_16_mem_arbiter
//
// Directed bench for mips_16_mem_arbiter. A MEM_LAT=2 instance is attached to
// a small behavioural memory; two extra instances (MEM_LAT=1 and 15) answer
// reads with mem_addr ^ 16'h5A5A for latency checks.
// -----------------------------------------------------------------------------
module tb_mips_16_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LATS [2] = '{1, 15};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Main instance signals
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_valid;
    logic [DW-1:0] if_rdata;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_gnt, ls_valid;
    logic [DW-1:0] ls_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    // Behavioural memory with a preload path
    logic [DW-1:0] mem [256];
    logic          pl_en = 1'b0;
    logic [7:0]    pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = mem_en ? mem[mem_addr[7:0]] : '0;

    mips_16_mem_arbiter #(.MEM_LAT(2), .AW(AW), .DW(DW)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Latency instances (fetch port only)
    logic          x_req [2];
    logic [AW-1:0] x_addr [2];
    logic          x_gnt [2];
    logic          x_valid [2];
    logic [DW-1:0] x_rdata [2];
    logic          x_lsgnt [2];
    logic          x_lsvalid [2];
    logic [DW-1:0] x_lsrdata [2];
    logic          x_men [2];
    logic          x_mwe [2];
    logic [AW-1:0] x_maddr [2];
    logic [DW-1:0] x_mwdata [2];
    logic [DW-1:0] x_mrdata [2];
    logic          x_busy [2];

    for (genvar g = 0; g < 2; g++) begin : g_lat
        assign x_mrdata[g] = x_maddr[g] ^ 16'h5A5A;
        mips_16_mem_arbiter #(.MEM_LAT(LATS[g]), .AW(AW), .DW(DW)) u_lat (
            .clk(clk), .reset(reset),
            .if_req(x_req[g]), .if_addr(x_addr[g]), .if_gnt(x_gnt[g]), .if_valid(x_valid[g]),
            .if_rdata(x_rdata[g]),
            .ls_req(1'b0), .ls_we(1'b0), .ls_addr(16'h0000), .ls_wdata(16'h0000),
            .ls_gnt(x_lsgnt[g]), .ls_valid(x_lsvalid[g]), .ls_rdata(x_lsrdata[g]),
            .mem_en(x_men[g]), .mem_we(x_mwe[g]), .mem_addr(x_maddr[g]), .mem_wdata(x_mwdata[g]),
            .mem_rdata(x_mrdata[g]), .busy(x_busy[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pl_en = 1'b1; pl_addr = 8'h10; pl_data = 16'h1234;
        tick();
        pl_en = 1'b0;
        checks++; if ({if_gnt, ls_gnt, if_valid, ls_valid, mem_en, mem_we, busy} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 0000000", {if_gnt, ls_gnt, if_valid, ls_valid, mem_en, mem_we, busy}); end
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        checks++; if (mem_wdata !== 16'h0000) begin failures++; $display("FAIL reset_mem_wdata: got %h expected 0000", mem_wdata); end
        checks++; if (if_rdata !== 16'h0000) begin failures++; $display("FAIL reset_if_rdata: got %h expected 0000", if_rdata); end
        checks++; if (ls_rdata !== 16'h0000) begin failures++; $display("FAIL reset_ls_rdata: got %h expected 0000", ls_rdata); end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_fetch();
        if_addr = 16'h0010; if_req = 1'b1;
        tick();
        checks++; if ({if_gnt, ls_gnt, mem_en, busy} !== 4'b1011) begin
            failures++; $display("FAIL fetch_c2: got %b expected 1011", {if_gnt, ls_gnt, mem_en, busy}); end
        checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL fetch_addr: got %h expected 0010", mem_addr); end
        if_req = 1'b0; if_addr = 16'hFFFF;
        tick();
        checks++; if ({if_gnt, mem_en, if_valid, mem_addr} !== {3'b010, 16'h0010}) begin
            failures++; $display("FAIL fetch_c3: got %b/%h expected 010/0010", {if_gnt, mem_en, if_valid}, mem_addr); end
        tick();
        checks++; if ({if_valid, mem_en, busy} !== 3'b101) begin
            failures++; $display("FAIL fetch_c4: got %b expected 101", {if_valid, mem_en, busy}); end
        checks++; if (if_rdata !== 16'h1234) begin failures++; $display("FAIL fetch_rdata: got %h expected 1234", if_rdata); end
        tick();
        checks++; if ({if_valid, busy, if_rdata} !== {2'b00, 16'h1234}) begin
            failures++; $display("FAIL fetch_c5: got %b/%h expected 00/1234", {if_valid, busy}, if_rdata); end
    endtask

    task automatic test_store_load();
        ls_we = 1'b1; ls_addr = 16'h0020; ls_wdata = 16'hBEEF; ls_req = 1'b1;
        tick();
        checks++; if ({ls_gnt, if_gnt, mem_we, mem_wdata} !== {3'b101, 16'hBEEF}) begin
            failures++; $display("FAIL store_c1: got %b/%h expected 101/beef", {ls_gnt, if_gnt, mem_we}, mem_wdata); end
        ls_req = 1'b0; ls_wdata = 16'h0000; ls_we = 1'b0;
        tick();
        checks++; if ({mem_we, mem_wdata, mem_addr} !== {1'b1, 16'hBEEF, 16'h0020}) begin
            failures++; $display("FAIL store_c2: got %b/%h/%h expected 1/beef/0020", mem_we, mem_wdata, mem_addr); end
        tick();
        checks++; if ({ls_valid, if_valid, mem_we, mem_en} !== 4'b1000) begin
            failures++; $display("FAIL store_valid: got %b expected 1000", {ls_valid, if_valid, mem_we, mem_en}); end
        checks++; if ({ls_rdata, if_rdata} !== {16'h0000, 16'h1234}) begin
            failures++; $display("FAIL store_rdata_kept: got %h/%h expected 0000/1234", ls_rdata, if_rdata); end
        tick();
        checks++; if (mem[8'h20] !== 16'hBEEF) begin failures++; $display("FAIL store_mem: got %h expected beef", mem[8'h20]); end
        ls_we = 1'b0; ls_addr = 16'h0020; ls_req = 1'b1;
        tick();
        checks++; if ({ls_gnt, mem_we, mem_en} !== 3'b101) begin
            failures++; $display("FAIL load_c1: got %b expected 101", {ls_gnt, mem_we, mem_en}); end
        ls_req = 1'b0;
        tick();
        tick();
        checks++; if ({ls_valid, ls_rdata} !== {1'b1, 16'hBEEF}) begin
            failures++; $display("FAIL load_data: got %b/%h expected 1/beef", ls_valid, ls_rdata); end
        tick();
        checks++; if ({ls_valid, busy} !== 2'b00) begin failures++; $display("FAIL load_end: got %b expected 00", {ls_valid, busy}); end
    endtask

    task automatic test_reset_abort();
        int n;
        ls_we = 1'b1; ls_addr = 16'h0030; ls_wdata = 16'h7777; ls_req = 1'b1;
        tick();
        checks++; if (ls_gnt !== 1'b1) begin failures++; $display("FAIL abort_gnt: got %b expected 1", ls_gnt); end
        tick();
        checks++; if ({mem_en, mem_we} !== 2'b11) begin failures++; $display("FAIL abort_access2: got %b expected 11", {mem_en, mem_we}); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({mem_en, mem_we, busy} !== 3'b000) begin
            failures++; $display("FAIL abort_async: got %b expected 000", {mem_en, mem_we, busy}); end
        tick();
        checks++; if ({ls_valid, if_valid} !== 2'b00) begin failures++; $display("FAIL abort_no_valid: got %b expected 00", {ls_valid, if_valid}); end
        reset = 1'b0;
        n = 0;
        do begin
            tick(); n++;
            if (ls_gnt) ls_req = 1'b0;
        end while (!ls_valid && n < 10);
        checks++; if (n !== 3) begin failures++; $display("FAIL abort_rereq_latency: got %0d expected 3", n); end
        tick();
        checks++; if ({busy, mem[8'h30]} !== {1'b0, 16'h7777}) begin
            failures++; $display("FAIL abort_rereq_done: got %b/%h expected 0/7777", busy, mem[8'h30]); end
    endtask

    task automatic test_tie();
        int n;
        logic exp_ls [4];
        logic seen_if, exp_seen;
`ifdef MEM_ARB_RR_EN
        exp_ls = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_seen = 1'b1;
`else
        exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1};
        exp_seen = 1'b0;
`endif
        seen_if = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        if_addr = 16'h0010; if_req = 1'b1;
        ls_we = 1'b0; ls_addr = 16'h0020; ls_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            do begin
                tick(); n++;
                if (if_gnt) seen_if = 1'b1;
            end while (!(if_gnt || ls_gnt) && n < 12);
            checks++; if (n !== ((t == 0) ? 1 : 4)) begin
                failures++; $display("FAIL tie_spacing[%0d]: got %0d cycles expected %0d", t, n, (t == 0) ? 1 : 4); end
            checks++; if ({if_gnt, ls_gnt} !== {!exp_ls[t], exp_ls[t]}) begin
                failures++; $display("FAIL tie_owner[%0d]: got if/ls=%b expected %b", t, {if_gnt, ls_gnt}, {!exp_ls[t], exp_ls[t]}); end
            checks++; if ({if_valid, ls_valid} !== 2'b00) begin
                failures++; $display("FAIL tie_gnt_valid[%0d]: got %b expected 00", t, {if_valid, ls_valid}); end
        end
        if_req = 1'b0; ls_req = 1'b0;
        n = 0;
        do begin
            tick(); n++;
            if (if_gnt) seen_if = 1'b1;
        end while (busy && n < 10);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tie_drain: got busy=%b expected 0", busy); end
        checks++; if (seen_if !== exp_seen) begin failures++; $display("FAIL tie_if_gnt_seen: got %b expected %b", seen_if, exp_seen); end
    endtask

    task automatic test_latency(input int k, input int lat);
        int n, gnt_n;
        logic [DW-1:0] exp_data;
        x_addr[k] = 16'h0040 + 16'(k);
        exp_data = x_addr[k] ^ 16'h5A5A;
        x_req[k] = 1'b1;
        n = 0; gnt_n = 0;
        do begin
            tick(); n++;
            if (x_gnt[k] && gnt_n == 0) gnt_n = n;
        end while (!x_valid[k] && n < 40);
        checks++; if (n !== lat + 1) begin failures++; $display("FAIL lat%0d_valid: got %0d cycles expected %0d", lat, n, lat + 1); end
        checks++; if (gnt_n !== 1) begin failures++; $display("FAIL lat%0d_gnt: got cycle %0d expected 1", lat, gnt_n); end
        checks++; if (x_rdata[k] !== exp_data) begin failures++; $display("FAIL lat%0d_rdata: got %h expected %h", lat, x_rdata[k], exp_data); end
        tick();
        checks++; if ({x_gnt[k], x_valid[k], x_busy[k]} !== 3'b000) begin
            failures++; $display("FAIL lat%0d_turnaround: got %b expected 000", lat, {x_gnt[k], x_valid[k], x_busy[k]}); end
        tick();
        checks++; if (x_gnt[k] !== 1'b1) begin failures++; $display("FAIL lat%0d_regrant: got %b expected 1", lat, x_gnt[k]); end
        x_req[k] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (x_busy[k] && n < 40);
        checks++; if (x_busy[k] !== 1'b0) begin failures++; $display("FAIL lat%0d_drain: got busy=%b expected 0", lat, x_busy[k]); end
    endtask

    initial begin
        x_req[0] = 1'b0; x_req[1] = 1'b0;
        x_addr[0] = '0;  x_addr[1] = '0;
        test_reset();
        test_fetch();
        test_store_load();
        test_reset_abort();
        test_tie();
        test_latency(0, LATS[0]);
        test_latency(1, LATS[1]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
